switch_debounce: RTL
====================

# switch_debounce

Input-side counterpart to the LED drivers: conditions the board's mechanical switches and push-buttons into clean, single-clock-domain signals. Each channel is synchronised, debounced by a per-channel state machine, and reported as a stable level plus one-cycle rise/fall pulses. An optional per-channel press counter is also available. The outputs feed LED/counter logic clocked by `board_clk`.

## Interface
- `N_INPUTS`, 4: number of independent input channels.
- `STABLE_CYCLES`, 1000000: cycles an input must hold a new value before it is accepted (10 ms at 100 MHz). Legal range is at least 2.
- `CNT_W`, 8: width of each press counter.
- `board_clk` input 1: sole clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `raw_in` input N_INPUTS: asynchronous switch/button pins.
- `level` output N_INPUTS: debounced level per channel.
- `rise` output N_INPUTS: one-cycle pulse when the debounced level goes 0→1.
- `fall` output N_INPUTS: one-cycle pulse when the debounced level goes 1→0.
- `press_cnt` output N_INPUTS*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W]; counts rise events.

## Operation
- **Synchroniser:** each channel passes through a 2-FF synchroniser, giving `sync[i]`. No other logic touches `raw_in`.
- **Per-channel FSM states:** STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Each channel has a dwell counter of width $clog2(STABLE_CYCLES).
- **Transitions:**
  - STABLE_LO & sync=1 → WAIT_HI, with cnt←0.
  - WAIT_HI & sync=0 → STABLE_LO, with cnt←0. There is no pulse, and this is the glitch rejection.
  - WAIT_HI & sync=1 & cnt≠STABLE_CYCLES-1 → cnt←cnt+1.
  - WAIT_HI & sync=1 & cnt=STABLE_CYCLES-1 → STABLE_HI, with level←1, rise←1, press_cnt←press_cnt+1.
  - The STABLE_HI/WAIT_LO side mirrors these rules and produces `fall`.
- **Level:** `level` is registered, equals 1 exactly in STABLE_HI and WAIT_LO, and changes only on accepted transitions.
- **Pulses:** `rise` and `fall` are registered, high for exactly one cycle, and never asserted together on one channel. Channels are fully independent, so several channels may pulse in the same cycle.
- **Press counter:** increments modulo 2^CNT_W, so 255→0 at CNT_W=8. It has no clear other than `reset`.
- **Reset:**
  - Every channel goes to STABLE_LO with cnt=0.
  - Sync FFs, `level`, `rise`, `fall` and `press_cnt` all go to 0.
  - Reset has priority over all other activity, including mid-debounce. A partially counted WAIT is discarded.
  - An input held high through reset is debounced afresh after reset, and produces a normal `rise` and a count increment.

## Timing
- **Latency:** if `raw_in[i]` goes high before edge 1 and stays high, `level[i]` and `rise[i]` assert after edge STABLE_CYCLES+3. This is 2 synchroniser edges, 1 edge entering WAIT, and STABLE_CYCLES counting edges. The same latency applies to falls.
- **Glitch rejection:** a glitch lasting fewer than STABLE_CYCLES+1 cycles at `sync` never changes `level`.
- **Counter bound:** the counter never exceeds STABLE_CYCLES-1 and has no wrap-around.
- **Back-to-back rises:** the minimum spacing between two `rise` pulses on one channel is 2*(STABLE_CYCLES+1) cycles.

## Configuration
- **Macro:** `SWITCH_DEBOUNCE_PRESS_CNT_EN`.
- **Defined:** the press counters are implemented as described above.
- **Undefined:** no counter registers exist, and `press_cnt` is driven constant 0. The port list is unchanged, and `level`/`rise`/`fall` behaviour is identical.

## Structure
- **Package `switch_debounce_pkg`:**
  - FSM state typedef (2-bit enum: STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3).
  - Synchroniser depth constant SYNC_STAGES=2.
  - A function returning the dwell-counter width for a given STABLE_CYCLES.
- **Sub-module `debounce_chan`:** one channel, containing the synchroniser, FSM, dwell counter, level/pulse registers and optional press counter. The top generates N_INPUTS instances.

## Test plan
Bench uses STABLE_CYCLES=4 and CNT_W=8.
1. **Clean rise:** raw_in[0] 0→1 held → level[0]=1 and a single rise[0] pulse after edge 7; press_cnt[7:0]=1; other channels stay 0.
2. **Glitch:** raw_in[1] high for 3 cycles, then low → level[1], rise[1] and press_cnt unchanged. A 10-cycle high → accepted.
3. **Bounce:** raw_in[2] toggles every 2 cycles for 20 cycles, then settles at 1 → exactly one rise[2], after settling plus 7 edges.
4. **Fall and wrap:** 256 full press/release cycles on channel 3 → 256 rise and 256 fall pulses; press_cnt[31:24] ends at 0.
5. **Reset mid-debounce:** reset asserted at cnt=2 in WAIT_HI with raw held high → all outputs 0 on the next edge. After release, rise arrives 7 edges later.
6. **Macro off:** rerun scenario 1 without the macro → press_cnt stays 0, level/rise identical.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_pkg
// Description : Shared FSM state encoding, synchroniser depth and dwell-counter
//               width helper for the switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Dwell counter only ever reaches STABLE_CYCLES-1; keep at least one bit.
    function automatic int dwell_width(input int stable_cycles);
        return (stable_cycles > 2) ? $clog2(stable_cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One switch channel: 2-FF synchroniser, debounce FSM with dwell
//               counter, registered level/rise/fall and optional press counter
//               (enabled by SWITCH_DEBOUNCE_PRESS_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int            DW     = dwell_width(STABLE_CYCLES);
    localparam logic [DW-1:0] c_LAST = DW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [DW-1:0]          cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (w_sync) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_sync) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_LAST) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_sync) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (w_sync) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef SWITCH_DEBOUNCE_PRESS_CNT_EN
    logic [CNT_W-1:0] press_q;
    logic             w_accept_hi;

    // Same condition that sets rise_q, so the count updates on the same edge.
    assign w_accept_hi = (state_q == WAIT_HI) && w_sync && (cnt_q == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= '0;
        end else if (w_accept_hi) begin
            press_q <= press_q + CNT_W'(1);
        end
    end

    assign press_cnt_o = press_q;
`else
    assign press_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : N-channel switch/button debouncer with level and rise/fall
//               pulses; per-channel press counters under
//               SWITCH_DEBOUNCE_PRESS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 8
) (
    input  logic                      board_clk,
    input  logic                      reset,
    input  logic [N_INPUTS-1:0]       raw_in,
    output logic [N_INPUTS-1:0]       level,
    output logic [N_INPUTS-1:0]       rise,
    output logic [N_INPUTS-1:0]       fall,
    output logic [N_INPUTS*CNT_W-1:0] press_cnt
);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk         (board_clk),
            .rst         (reset),
            .raw_i       (raw_in[i]),
            .level_o     (level[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i]),
            .press_cnt_o (press_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
`default_nettype wire
